// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour command sequencer.
//   - state_e     : sequencer FSM states
//   - OP_* / HDG_*: movement opcodes and heading fields of a 16-bit command
//   - RESP_*      : response bytes returned toward the UART side
//   - decode_move : one-hot knight move -> {dx_neg, |dx|, dy_neg, |dy|}
//   - is_one_hot  : legality test for a move byte
// decode_move is kept free of any sequencer state so a solver golden model
// can reuse it directly.
package tour_pkg;

  localparam int NUM_MOVES = 24;

  localparam logic [3:0] OP_MOVE    = 4'h2;  // vertical leg
  localparam logic [3:0] OP_FANFARE = 4'h3;  // horizontal leg, with fanfare

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_FINAL = 8'hA5;  // last leg done, or UART path
  localparam logic [7:0] RESP_INTER = 8'h5A;  // intermediate leg done

  // Explicit encodings keep the state values stable for legacy probes.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_VERT  = 3'd2,
    ST_HOLDV = 3'd3,
    ST_HORZ  = 3'd4,
    ST_HOLDH = 3'd5
  } state_e;

  // Sign/magnitude form of a knight move; magnitudes are 1 or 2.
  typedef struct packed {
    logic       dx_neg;
    logic [1:0] dx_mag;
    logic       dy_neg;
    logic [1:0] dy_mag;
  } move_vec_t;

  function automatic move_vec_t decode_move(input logic [7:0] mv);
    move_vec_t v;
    case (mv)
      8'h01:   v = '{1'b0, 2'd1, 1'b0, 2'd2};  // (+1,+2)
      8'h02:   v = '{1'b1, 2'd1, 1'b0, 2'd2};  // (-1,+2)
      8'h04:   v = '{1'b1, 2'd2, 1'b0, 2'd1};  // (-2,+1)
      8'h08:   v = '{1'b1, 2'd2, 1'b1, 2'd1};  // (-2,-1)
      8'h10:   v = '{1'b1, 2'd1, 1'b1, 2'd2};  // (-1,-2)
      8'h20:   v = '{1'b0, 2'd1, 1'b1, 2'd2};  // (+1,-2)
      8'h40:   v = '{1'b0, 2'd2, 1'b1, 2'd1};  // (+2,-1)
      8'h80:   v = '{1'b0, 2'd2, 1'b0, 2'd1};  // (+2,+1)
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/tour_cmd_sequencer_if.sv
// Command-path bundle around the sequencer: the UART wrapper side
// (cmd_UART / cmd_rdy_UART / clr_cmd_rdy_UART) and the command-processor
// side (cmd / cmd_rdy / clr_cmd_rdy / send_resp / resp).
//   master : the sequencer
//   slave  : the surrounding UART wrapper and command processor
interface tour_cmd_sequencer_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_cmd_mux.sv
// 2:1 command multiplexer between the UART path and the tour sequencer.
//   sel_tour          : 1 while a tour is running
//   cmd_UART/cmd_rdy_UART, clr_cmd_rdy_UART : UART wrapper side
//   tour_cmd/tour_cmd_rdy/tour_resp         : sequencer-generated values
//   cmd/cmd_rdy/clr_cmd_rdy/resp            : command-processor side
// While a tour runs the UART command is held off: its clear is forced low
// so a pending UART command survives until the tour finishes.
module tour_cmd_mux
  import tour_pkg::*;
(
  input  logic        sel_tour,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  input  logic [7:0]  tour_resp,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  assign cmd              = sel_tour ? tour_cmd     : cmd_UART;
  assign cmd_rdy          = sel_tour ? tour_cmd_rdy : cmd_rdy_UART;
  assign clr_cmd_rdy_UART = sel_tour ? 1'b0         : clr_cmd_rdy;
  assign resp             = sel_tour ? tour_resp    : RESP_FINAL;

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Knight's-tour command sequencer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_tour  : one-cycle pulse from the solver's done
//   move        : one-hot move read from the solver at mv_indx
//   mv_indx     : registered index of the move being read
//   tour_done   : one-cycle pulse after the last leg's send_resp
//   tour_err    : one-cycle pulse after a non-one-hot move is read
//   cmd_bus     : UART / command-processor handshake bundle (master side)
// Each move becomes two commands, vertical leg (OP_MOVE) then horizontal
// leg (OP_FANFARE). A leg is offered with cmd_rdy until clr_cmd_rdy, then
// held until send_resp reports the motion finished.
module tour_cmd_sequencer
  import tour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  output logic        tour_done,
  output logic        tour_err,
  tour_cmd_sequencer_if.master cmd_bus
);

  state_e      state;
  logic [7:0]  mv_reg;
  move_vec_t   mv_vec;
  logic        last_move;
  logic [7:0]  vert_hdg;
  logic [7:0]  horz_hdg;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic [15:0] tour_cmd;
  logic        tour_cmd_rdy;
  logic [7:0]  tour_resp;

  assign last_move = (mv_indx == 5'(NUM_MOVES - 1));

  assign mv_vec   = decode_move(mv_reg);
  assign vert_hdg = mv_vec.dy_neg ? HDG_S : HDG_N;
  assign horz_hdg = mv_vec.dx_neg ? HDG_W : HDG_E;
  assign vert_cmd = {OP_MOVE,    vert_hdg, {2'b00, mv_vec.dy_mag}};
  assign horz_cmd = {OP_FANFARE, horz_hdg, {2'b00, mv_vec.dx_mag}};

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mv_indx   <= '0;
      mv_reg    <= '0;
      tour_done <= 1'b0;
      tour_err  <= 1'b0;
    end else begin
      tour_done <= 1'b0;
      tour_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_tour) begin
            state   <= ST_LOAD;
            mv_indx <= '0;
          end
        end
        ST_LOAD: begin
          mv_reg <= move;
          if (!is_one_hot(move)) begin
            tour_err <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_VERT;
          end
        end
        // send_resp before acceptance is meaningless, so only clr_cmd_rdy
        // is watched while a leg is being offered.
        ST_VERT:  if (cmd_bus.clr_cmd_rdy) state <= ST_HOLDV;
        ST_HOLDV: if (cmd_bus.send_resp)   state <= ST_HORZ;
        ST_HORZ:  if (cmd_bus.clr_cmd_rdy) state <= ST_HOLDH;
        ST_HOLDH: begin
          if (cmd_bus.send_resp) begin
            if (last_move) begin
              tour_done <= 1'b1;
              mv_indx   <= '0;
              state     <= ST_IDLE;
            end else begin
              mv_indx <= mv_indx + 5'd1;
              state   <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tour_cmd     = '0;
    tour_cmd_rdy = 1'b0;
    tour_resp    = RESP_INTER;
    case (state)
      ST_VERT: begin
        tour_cmd     = vert_cmd;
        tour_cmd_rdy = 1'b1;
      end
      ST_HOLDV: tour_cmd = vert_cmd;
      ST_HORZ: begin
        tour_cmd     = horz_cmd;
        tour_cmd_rdy = 1'b1;
      end
      ST_HOLDH: begin
        tour_cmd = horz_cmd;
        if (last_move) tour_resp = RESP_FINAL;
      end
      default: ;
    endcase
  end

  tour_cmd_mux u_mux (
    .sel_tour         (state != ST_IDLE),
    .cmd_UART         (cmd_bus.cmd_UART),
    .cmd_rdy_UART     (cmd_bus.cmd_rdy_UART),
    .clr_cmd_rdy_UART (cmd_bus.clr_cmd_rdy_UART),
    .tour_cmd         (tour_cmd),
    .tour_cmd_rdy     (tour_cmd_rdy),
    .tour_resp        (tour_resp),
    .clr_cmd_rdy      (cmd_bus.clr_cmd_rdy),
    .cmd              (cmd_bus.cmd),
    .cmd_rdy          (cmd_bus.cmd_rdy),
    .resp             (cmd_bus.resp)
  );

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Self-checking bench for tour_cmd_sequencer. A solver model supplies
// random one-hot moves; expected commands come from a (dx,dy) table and
// sign/magnitude arithmetic. Inputs change 1 ns after the rising edge and
// outputs are sampled 2 ns after it.
module tb_tour_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_tour = 1'b0;
  logic [7:0] move;
  logic [4:0] mv_indx;
  logic       tour_done;
  logic       tour_err;

  tour_cmd_sequencer_if bus ();

  tour_cmd_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_tour (start_tour),
    .move       (move),
    .mv_indx    (mv_indx),
    .tour_done  (tour_done),
    .tour_err   (tour_err),
    .cmd_bus    (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int leg_cnt = 0;

  // Solver model: move table addressed by the DUT's index, with override.
  logic [7:0] tour_mem [32];
  logic       move_ovr_en = 1'b0;
  logic [7:0] move_ovr = 8'h00;
  assign move = move_ovr_en ? move_ovr : tour_mem[mv_indx];

  // Knight move table indexed by the one-hot bit position.
  int dx_tab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_tab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always @(negedge clk) begin
    if (tour_done === 1'b1) done_cnt++;
    if (tour_err === 1'b1) err_cnt++;
  end

  function automatic logic [15:0] exp_cmd(input logic [7:0] mv, input bit vert);
    int b;
    int d;
    logic [7:0] hdg;
    logic [3:0] op;
    b = 0;
    for (int k = 0; k < 8; k++) if (mv[k]) b = k;
    d = vert ? dy_tab[b] : dx_tab[b];
    if (vert) hdg = (d > 0) ? 8'h00 : 8'h7F;
    else      hdg = (d > 0) ? 8'hBF : 8'h3F;
    op = vert ? 4'h2 : 4'h3;
    return {op, hdg, 4'(d < 0 ? -d : d)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fill_random_tour();
    for (int k = 0; k < 32; k++) tour_mem[k] = 8'(1 << $urandom_range(0, 7));
  endtask

  // Pulses start_tour for one cycle; returns at the LOAD cycle (T+1).
  task automatic pulse_start(input string name);
    cyc();
    start_tour = 1'b1;
    bus.cmd_rdy_UART = 1'b1;
    cyc();
    start_tour = 1'b0;
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL %s load_cmd_rdy: got %b want 0", name, bus.cmd_rdy);
    end
  endtask

  // Runs one leg: wait for cmd_rdy, check it, accept, hold, then finish.
  task automatic run_leg(input logic [15:0] exp_c, input logic [7:0] hold_resp,
                         input int exp_idx, input bit inject_start, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (bus.cmd_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
      #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s rdy_timeout: got cmd_rdy=%b want 1 within 10 cycles", name, bus.cmd_rdy);
      return;
    end
    leg_cnt++;
    checks++;
    if (bus.cmd !== exp_c) begin
      failures++;
      $display("FAIL %s cmd: got %h want %h", name, bus.cmd, exp_c);
    end
    checks++;
    if (mv_indx !== 5'(exp_idx)) begin
      failures++;
      $display("FAIL %s mv_indx: got %0d want %0d", name, mv_indx, exp_idx);
    end
    if ($urandom_range(0, 2) == 0) begin
      cyc();
      bus.send_resp = 1'b1;
      cyc();
      bus.send_resp = 1'b0;
      #1;
      checks++;
      if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp_c) begin
        failures++;
        $display("FAIL %s early_send_resp: got rdy=%b cmd=%h want 1 %h", name, bus.cmd_rdy, bus.cmd, exp_c);
      end
    end
    cyc();
    bus.clr_cmd_rdy = 1'b1;
    bus.send_resp = 1'($urandom_range(0, 1));
    bus.cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b0) begin
      failures++;
      $display("FAIL %s uart_held_off: got clr_cmd_rdy_UART=%b want 0", name, bus.clr_cmd_rdy_UART);
    end
    cyc();
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    bus.cmd_rdy_UART = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b0 || bus.resp !== hold_resp) begin
      failures++;
      $display("FAIL %s hold: got rdy=%b resp=%h want 0 %h", name, bus.cmd_rdy, bus.resp, hold_resp);
    end
    if (inject_start) begin
      cyc();
      start_tour = 1'b1;
      cyc();
      start_tour = 1'b0;
      #1;
      checks++;
      if (mv_indx !== 5'(exp_idx) || bus.cmd_rdy !== 1'b0) begin
        failures++;
        $display("FAIL %s start_ignored: got idx=%0d rdy=%b want %0d 0", name, mv_indx, bus.cmd_rdy, exp_idx);
      end
    end
    cyc();
    bus.clr_cmd_rdy = 1'b1;
    cyc();
    bus.clr_cmd_rdy = 1'b0;
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL %s clr_in_hold: got cmd_rdy=%b want 0", name, bus.cmd_rdy);
    end
    repeat ($urandom_range(0, 2)) cyc();
    cyc();
    bus.send_resp = 1'b1;
    cyc();
    bus.send_resp = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.cmd_rdy_UART = 1'b1;
    bus.cmd_UART = 16'hBEEF;
    bus.clr_cmd_rdy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hBEEF) begin
      failures++;
      $display("FAIL reset_passthru: got rdy=%b cmd=%h want 1 beef", bus.cmd_rdy, bus.cmd);
    end
    checks++;
    if (mv_indx !== 5'd0) begin
      failures++;
      $display("FAIL reset_mv_indx: got %0d want 0", mv_indx);
    end
    checks++;
    if (tour_done !== 1'b0 || tour_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: got done=%b err=%b want 0 0", tour_done, tour_err);
    end
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b1 || bus.resp !== 8'hA5) begin
      failures++;
      $display("FAIL reset_uart_side: got clr=%b resp=%h want 1 a5", bus.clr_cmd_rdy_UART, bus.resp);
    end
    bus.clr_cmd_rdy = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
  endtask

  task automatic test_idle_passthrough();
    logic [15:0] c;
    logic r;
    logic k;
    for (int i = 0; i < 6; i++) begin
      c = (i == 0) ? 16'h2003 : 16'($urandom);
      r = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      k = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
      bus.cmd_UART = c;
      bus.cmd_rdy_UART = r;
      bus.clr_cmd_rdy = k;
      #1;
      checks++;
      if (bus.cmd !== c || bus.cmd_rdy !== r) begin
        failures++;
        $display("FAIL idle_cmd[%0d]: got %h/%b want %h/%b", i, bus.cmd, bus.cmd_rdy, c, r);
      end
      checks++;
      if (bus.clr_cmd_rdy_UART !== k || bus.resp !== 8'hA5) begin
        failures++;
        $display("FAIL idle_clr_resp[%0d]: got %b/%h want %b/a5", i, bus.clr_cmd_rdy_UART, bus.resp, k);
      end
    end
    cyc();
    bus.clr_cmd_rdy = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    #1;
  endtask

  task automatic test_single_move();
    tour_mem[0] = 8'h01;
    pulse_start("single");
    cyc();
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h2002) begin
      failures++;
      $display("FAIL single_latency: got rdy=%b cmd=%h at T+2 want 1 2002", bus.cmd_rdy, bus.cmd);
    end
    run_leg(16'h2002, 8'h5A, 0, 1'b0, "single_vert");
    run_leg(16'h3BF1, 8'h5A, 0, 1'b0, "single_horz");
    do_reset();
  endtask

  task automatic test_negative_decode();
    tour_mem[0] = 8'h08;
    pulse_start("neg");
    run_leg(16'h27F1, 8'h5A, 0, 1'b0, "neg_vert");
    run_leg(16'h33F2, 8'h5A, 0, 1'b0, "neg_horz");
    do_reset();
  endtask

  task automatic test_full_tour();
    int d0;
    logic [15:0] c;
    fill_random_tour();
    d0 = done_cnt;
    leg_cnt = 0;
    pulse_start("tour");
    for (int i = 0; i < 24; i++) begin
      run_leg(exp_cmd(tour_mem[i], 1'b1), 8'h5A, i, (i == 5), "tour_vert");
      run_leg(exp_cmd(tour_mem[i], 1'b0), (i == 23) ? 8'hA5 : 8'h5A, i, 1'b0, "tour_horz");
    end
    repeat (3) cyc();
    #1;
    checks++;
    if (leg_cnt !== 48) begin
      failures++;
      $display("FAIL tour_leg_count: got %0d want 48", leg_cnt);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL tour_done_count: got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (mv_indx !== 5'd0) begin
      failures++;
      $display("FAIL tour_end_idx: got %0d want 0", mv_indx);
    end
    c = 16'($urandom);
    bus.cmd_UART = c;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (bus.cmd !== c || bus.cmd_rdy !== 1'b1 || bus.resp !== 8'hA5) begin
      failures++;
      $display("FAIL tour_resume_uart: got %h/%b/%h want %h/1/a5", bus.cmd, bus.cmd_rdy, bus.resp, c);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] pats [2];
    int e0;
    int a;
    int b;
    a = $urandom_range(0, 7);
    b = (a + $urandom_range(1, 7)) % 8;
    pats[0] = 8'h00;
    pats[1] = 8'(1 << a) | 8'(1 << b);
    for (int p = 0; p < 2; p++) begin
      e0 = err_cnt;
      tour_mem[0] = pats[p];
      pulse_start("illegal");
      bus.cmd_rdy_UART = 1'b0;
      cyc();
      #1;
      checks++;
      if (tour_err !== 1'b1 || bus.cmd_rdy !== 1'b0) begin
        failures++;
        $display("FAIL illegal_err[%0d]: got err=%b rdy=%b want 1 0", p, tour_err, bus.cmd_rdy);
      end
      cyc();
      #1;
      checks++;
      if (tour_err !== 1'b0 || bus.cmd_rdy !== 1'b0 || err_cnt - e0 !== 1) begin
        failures++;
        $display("FAIL illegal_pulse[%0d]: got err=%b rdy=%b cnt=%0d want 0 0 1", p, tour_err, bus.cmd_rdy, err_cnt - e0);
      end
      bus.cmd_rdy_UART = 1'b1;
      #1;
      checks++;
      if (bus.cmd_rdy !== 1'b1) begin
        failures++;
        $display("FAIL illegal_idle[%0d]: got cmd_rdy=%b want 1", p, bus.cmd_rdy);
      end
    end
  endtask

  task automatic test_reset_mid_tour();
    int d0;
    fill_random_tour();
    d0 = done_cnt;
    pulse_start("rst");
    for (int i = 0; i < 7; i++) begin
      run_leg(exp_cmd(tour_mem[i], 1'b1), 8'h5A, i, 1'b0, "rst_vert");
      run_leg(exp_cmd(tour_mem[i], 1'b0), 8'h5A, i, 1'b0, "rst_horz");
    end
    run_leg(exp_cmd(tour_mem[7], 1'b1), 8'h5A, 7, 1'b0, "rst_vert7");
    checks++;
    if (bus.cmd_rdy !== 1'b1 || mv_indx !== 5'd7) begin
      failures++;
      $display("FAIL rst_pre_horz: got rdy=%b idx=%0d want 1 7", bus.cmd_rdy, mv_indx);
    end
    bus.cmd_rdy_UART = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b0 || mv_indx !== 5'd0) begin
      failures++;
      $display("FAIL rst_async: got rdy=%b idx=%0d want 0 0", bus.cmd_rdy, mv_indx);
    end
    bus.cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rst_tracks_uart: got %b want 1", bus.cmd_rdy);
    end
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    #1;
    checks++;
    if (done_cnt !== d0) begin
      failures++;
      $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    pulse_start("restart");
    run_leg(exp_cmd(tour_mem[0], 1'b1), 8'h5A, 0, 1'b0, "restart_vert");
    do_reset();
  endtask

  initial begin
    bus.cmd_UART = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    for (int k = 0; k < 32; k++) tour_mem[k] = 8'h01;
    test_reset();
    test_idle_passthrough();
    test_single_move();
    test_negative_decode();
    test_full_tour();
    test_illegal();
    test_reset_mid_tour();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
